mem_line_ctrl: RTL and testbench
================================

Name: mem_line_ctrl

Overview:
- Initiator end of the 128-bit line protocol. The slow data and instruction memories are the responders; this block drives mem_read, mem_write, mem_addr and mem_wdata, and consumes mem_rdata and mem_ready.
- Sits between a cache controller and one slow memory: one instance for the D-side, one for the I-side.
- Each accepted request runs an optional dirty-line writeback, then an optional line refill. It returns the refill line, a completion pulse and a stall-cycle count.

Parameters:
- TIMEOUT, 1024: cycles allowed per memory transaction before abort.
- CNT_W, 16: width of the saturating stall-cycle counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  cache requests a line operation
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_wb  in  1  request includes a writeback
- req_wb_addr  in  28  writeback line address (byte address bits 31:4)
- req_wb_data  in  128  writeback line data
- req_rd  in  1  request includes a refill
- req_rd_addr  in  28  refill line address (bits 31:4)
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  128  refill line; valid with resp_valid
- resp_err  out  1  completion was a timeout abort; valid with resp_valid
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_addr  out  28  memory line address
- mem_wdata  out  128  memory write data
- mem_rdata  in  128  memory read data; valid when mem_ready is high during a read
- mem_ready  in  1  one-cycle completion from memory
- stall_cnt  out  CNT_W  saturating count of cycles spent outside IDLE since reset

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE; all outputs 0 except req_ready=1. stall_cnt=0; captured request fields are cleared.
- Reset mid-transaction: strobes drop immediately and no response is produced.
- All memory-side outputs are driven directly from flops; no combinational path from any input to any output.
- States: IDLE, WB, WB_GAP, RD, DONE.
- IDLE: req_ready=1. When req_valid=1:
  - capture req_wb, both addresses, and req_wb_data.
  - next state is WB if req_wb=1; else RD if req_rd=1; else DONE.
  - req_* inputs are ignored outside IDLE.
- WB:
  - mem_write=1, mem_addr=wb_addr, mem_wdata=wb_data, all held stable until mem_ready.
  - On mem_ready: mem_write=0 next cycle. Go to WB_GAP if the captured req_rd=1, else DONE.
- WB_GAP: exactly one cycle with mem_read=mem_write=0, then RD. This guarantees a strobe-low cycle between back-to-back transactions.
- RD:
  - mem_read=1, mem_addr=rd_addr, held stable.
  - On mem_ready: capture mem_rdata into resp_rdata, drop mem_read next cycle, go to DONE.
- DONE: resp_valid=1 for exactly one cycle, then IDLE.
  - resp_rdata is held until the next refill capture, a timeout, or reset.
  - A request with neither req_wb nor req_rd passes through DONE with no memory traffic; resp_rdata is unchanged.
- mem_read and mem_write are never high simultaneously.
- mem_ready while in IDLE, WB_GAP or DONE is ignored.
- Minimum latency, with mem_ready in the first strobe cycle, from the acceptance edge to resp_valid:
  - refill only: 3 cycles.
  - writeback + refill: 5 cycles.
  - no-op: 1 cycle.
- Timeout:
  - A wait counter clears on entry to WB or RD and increments each cycle in that state without mem_ready.
  - At count TIMEOUT-1 without mem_ready: drop the strobe next cycle and skip the remaining phases. Enter DONE with resp_err=1 and resp_rdata=0.
  - resp_err=0 on normal completion.
- stall_cnt: increments by 1 every cycle the state is not IDLE. Saturates at all-ones with no wrap.
- Back-to-back: a new request is accepted only in IDLE, so the earliest acceptance after a completion is the cycle after resp_valid.

Test Plan:
- Refill only: req_rd=1, rd_addr=28'h0000010, memory ready after 4 cycles with rdata=128'hDEADBEEF_... → mem_read high 4 cycles at addr 0000010, then low. resp_valid pulses once with that rdata and resp_err=0.
- Writeback + refill: wb_addr=28'h0000020, wb_data=128'h1111..., rd_addr=28'h0000030 → mem_write phase, exactly one strobe-low gap cycle, then mem_read phase. resp_valid follows the read; the memory holds 1111... at 0000020.
- No-op: req_wb=req_rd=0 → no strobes; resp_valid exactly 1 cycle after acceptance; resp_rdata unchanged.
- Timeout: TIMEOUT=8, memory never responds → mem_read high for exactly 8 cycles, then resp_valid=1, resp_err=1, resp_rdata=0; next request is accepted normally.
- Reset mid-RD: rst_n low for 2 cycles while mem_read=1 → mem_read=0 immediately and req_ready=1. No resp_valid; stall_cnt=0.
- Stray and saturating inputs: mem_ready pulsed while IDLE → no state change. With CNT_W=4 and 20 stall cycles → stall_cnt holds 4'hF.

Source files
------------

// File: rtl/mem_line_ctrl.sv
// mem_line_ctrl: initiator for the 128-bit line memory protocol.
// Each accepted request runs an optional dirty-line writeback and then an
// optional refill. It finishes with a one-cycle completion pulse that carries
// the refill line and a timeout flag. Every output comes straight from a flop.
//
// Timing: when a request is accepted, the address (and write data) flops load
// on that edge. The strobe rises one cycle later, so the slow memory always
// sees a stable address for a full cycle before the strobe. Between a
// writeback and its refill, WB_GAP loads the refill address and raises
// mem_read on its exit edge. This leaves exactly one strobe-low cycle
// between the two transactions.
module mem_line_ctrl #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_wb,
  input  logic [27:0]      req_wb_addr,
  input  logic [127:0]     req_wb_data,
  input  logic             req_rd,
  input  logic [27:0]      req_rd_addr,
  output logic             resp_valid,
  output logic [127:0]     resp_rdata,
  output logic             resp_err,
  output logic             mem_read,
  output logic             mem_write,
  output logic [27:0]      mem_addr,
  output logic [127:0]     mem_wdata,
  input  logic [127:0]     mem_rdata,
  input  logic             mem_ready,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WB     = 3'd1,
    S_WB_GAP = 3'd2,
    S_RD     = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t             state_q;
  logic               req_ready_q;
  logic               resp_valid_q;
  logic [127:0]       resp_rdata_q;
  logic               resp_err_q;
  logic               mem_read_q;
  logic               mem_write_q;
  logic [27:0]        mem_addr_q;
  logic [127:0]       mem_wdata_q;
  logic               rd_pend_q;
  logic [27:0]        rd_addr_q;
  logic [WAIT_W-1:0]  wait_q;
  logic [CNT_W-1:0]   stall_q;

  // Request sequencing: capture, writeback, gap, refill, completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rd_pend_q    <= 1'b0;
      rd_addr_q    <= '0;
      wait_q       <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            req_ready_q <= 1'b0;
            rd_pend_q   <= req_rd;
            rd_addr_q   <= req_rd_addr;
            wait_q      <= '0;
            if (req_wb) begin
              state_q     <= S_WB;
              mem_addr_q  <= req_wb_addr;
              mem_wdata_q <= req_wb_data;
            end else if (req_rd) begin
              state_q    <= S_RD;
              mem_addr_q <= req_rd_addr;
            end else begin
              state_q      <= S_DONE;
              resp_valid_q <= 1'b1;
            end
          end
        end
        S_WB: begin
          if (!mem_write_q) begin
            mem_write_q <= 1'b1;
            wait_q      <= '0;
          end else if (mem_ready) begin
            mem_write_q <= 1'b0;
            if (rd_pend_q) begin
              state_q    <= S_WB_GAP;
              mem_addr_q <= rd_addr_q;
            end else begin
              state_q      <= S_DONE;
              resp_valid_q <= 1'b1;
            end
          end else if (wait_q == WAIT_LAST) begin
            // Timeout: abandon the writeback and any pending refill.
            mem_write_q  <= 1'b0;
            state_q      <= S_DONE;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= '0;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        S_WB_GAP: begin
          state_q    <= S_RD;
          mem_read_q <= 1'b1;
          wait_q     <= '0;
        end
        S_RD: begin
          if (!mem_read_q) begin
            mem_read_q <= 1'b1;
            wait_q     <= '0;
          end else if (mem_ready) begin
            mem_read_q   <= 1'b0;
            resp_rdata_q <= mem_rdata;
            state_q      <= S_DONE;
            resp_valid_q <= 1'b1;
          end else if (wait_q == WAIT_LAST) begin
            mem_read_q   <= 1'b0;
            state_q      <= S_DONE;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= '0;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        S_DONE: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
          resp_err_q  <= 1'b0;
        end
        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of cycles spent outside IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (state_q != S_IDLE && !(&stall_q)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_mem_line_ctrl.sv
// Bench for mem_line_ctrl. Two instances share all inputs: the main one
// (CNT_W=16) and one with a 4-bit stall counter. A per-transaction schedule
// model predicts every output cycle; a responder plays the slow memory.
module tb_mem_line_ctrl;
  localparam int T = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n = 1'b1;
  logic         req_valid = 1'b0, req_wb = 1'b0, req_rd = 1'b0;
  logic [27:0]  req_wb_addr = '0, req_rd_addr = '0;
  logic [127:0] req_wb_data = '0;
  logic [127:0] mem_rdata = '0;
  logic         mem_ready = 1'b0;

  logic         req_ready, resp_valid, resp_err, mem_read, mem_write;
  logic [127:0] resp_rdata, mem_wdata;
  logic [27:0]  mem_addr;
  logic [15:0]  stall_cnt;

  logic         s_req_ready, s_resp_valid, s_resp_err, s_mem_read, s_mem_write;
  logic [127:0] s_resp_rdata, s_mem_wdata;
  logic [27:0]  s_mem_addr;
  logic [3:0]   s_stall;

  mem_line_ctrl #(.TIMEOUT(T), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_wb(req_wb), .req_wb_addr(req_wb_addr), .req_wb_data(req_wb_data),
    .req_rd(req_rd), .req_rd_addr(req_rd_addr), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_read(mem_read),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall_cnt(stall_cnt));

  mem_line_ctrl #(.TIMEOUT(T), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(s_req_ready),
    .req_wb(req_wb), .req_wb_addr(req_wb_addr), .req_wb_data(req_wb_data),
    .req_rd(req_rd), .req_rd_addr(req_rd_addr), .resp_valid(s_resp_valid),
    .resp_rdata(s_resp_rdata), .resp_err(s_resp_err), .mem_read(s_mem_read),
    .mem_write(s_mem_write), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall_cnt(s_stall));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%h expected=%h", nm, $time, act, exp);
    end
  endtask

  // Expected outputs for one cycle.
  typedef struct {
    logic         rdy, rd, wr, rv, err;
    logic [27:0]  addr;
    logic [127:0] wd, rdata;
  } exp_t;

  exp_t         q[$];
  logic [127:0] m_rdata = '0;
  int           m_stall = 0;

  function automatic void push(input logic rd, input logic wr, input logic rv, input logic err,
                               input logic [27:0] addr, input logic [127:0] wd,
                               input logic [127:0] rdata);
    exp_t e;
    e.rdy = 1'b0; e.rd = rd; e.wr = wr; e.rv = rv; e.err = err;
    e.addr = addr; e.wd = wd; e.rdata = rdata;
    q.push_back(e);
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    exp_t e;
    logic busy;
    int   sat;
    if (q.size() > 0) begin
      e = q.pop_front();
      busy = 1'b1;
      m_rdata = e.rdata;
    end else begin
      e.rdy = 1'b1; e.rd = 1'b0; e.wr = 1'b0; e.rv = 1'b0; e.err = 1'b0;
      e.addr = '0; e.wd = '0; e.rdata = m_rdata;
      busy = 1'b0;
    end
    sat = (m_stall > 15) ? 15 : m_stall;
    chk("req_ready", req_ready, e.rdy);
    chk("mem_read", mem_read, e.rd);
    chk("mem_write", mem_write, e.wr);
    chk("resp_valid", resp_valid, e.rv);
    chk("resp_rdata", resp_rdata, e.rdata);
    if (e.rd || e.wr) chk("mem_addr", mem_addr, e.addr);
    if (e.wr) chk("mem_wdata", mem_wdata, e.wd);
    if (e.rv) chk("resp_err", resp_err, e.err);
    chk("stall_cnt", stall_cnt, m_stall);
    chk("sat_stall_cnt", s_stall, sat);
    chk("sat_req_ready", s_req_ready, e.rdy);
    chk("sat_strobes", {s_mem_read, s_mem_write, s_resp_valid}, {e.rd, e.wr, e.rv});
    chk("sat_resp_rdata", s_resp_rdata, e.rdata);
    if (e.rd || e.wr) chk("sat_mem_addr", s_mem_addr, e.addr);
    if (e.wr) chk("sat_mem_wdata", s_mem_wdata, e.wd);
    if (e.rv) chk("sat_resp_err", s_resp_err, e.err);
    if (busy) m_stall++;
  end

  // Slow memory: ready on the Nth consecutive strobe cycle (0 = never).
  int           scnt = 0, dly_wb = 0, dly_rd = 0;
  logic         stray = 1'b0;
  logic [127:0] rd_val = '0;
  logic [27:0]  last_waddr = '0;
  logic [127:0] last_wdata = '0;
  int           cyc = 0, rd_hi = 0, wr_hi = 0, resp_cnt = 0, resp_cyc = 0, acc_cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (mem_read || mem_write) scnt++; else scnt = 0;
    mem_ready = stray || (mem_write && dly_wb != 0 && scnt == dly_wb)
                      || (mem_read && dly_rd != 0 && scnt == dly_rd);
    mem_rdata = (mem_read && mem_ready) ? rd_val : ~rd_val;
    if (mem_write && mem_ready) begin
      last_waddr = mem_addr;
      last_wdata = mem_wdata;
    end
    if (mem_read) rd_hi++;
    if (mem_write) wr_hi++;
    if (resp_valid) begin
      resp_cnt++;
      resp_cyc = cyc;
    end
  end

  function automatic int nstrobe(input int d);
    return (d >= 1 && d <= T) ? d : T;
  endfunction

  function automatic void plan_read(input logic [27:0] ra, input int dr, input logic [127:0] rv);
    for (int i = 0; i < nstrobe(dr); i++) push(1'b1, 1'b0, 1'b0, 1'b0, ra, '0, m_rdata);
    if (dr >= 1 && dr <= T) push(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, rv);
    else                    push(1'b0, 1'b0, 1'b1, 1'b1, '0, '0, '0);
  endfunction

  task automatic do_req(input logic wb, input logic [27:0] wa, input logic [127:0] wd,
                        input logic rd, input logic [27:0] ra, input int dw, input int dr,
                        input logic [127:0] rv);
    int i;
    @(posedge clk); #2;
    dly_wb = dw; dly_rd = dr; rd_val = rv;
    rd_hi = 0; wr_hi = 0; resp_cnt = 0;
    req_valid = 1'b1; req_wb = wb; req_wb_addr = wa; req_wb_data = wd;
    req_rd = rd; req_rd_addr = ra;
    @(posedge clk);
    acc_cyc = cyc;
    #2;
    // Inputs change after acceptance; the captured copy must be used.
    req_valid = 1'b0; req_wb = ~wb; req_rd = ~rd;
    req_wb_addr = ~wa; req_rd_addr = ~ra; req_wb_data = ~wd;
    if (wb) begin
      push(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, m_rdata);
      for (int k = 0; k < nstrobe(dw); k++) push(1'b0, 1'b1, 1'b0, 1'b0, wa, wd, m_rdata);
      if (!(dw >= 1 && dw <= T))
        push(1'b0, 1'b0, 1'b1, 1'b1, '0, '0, '0);
      else if (rd) begin
        push(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, m_rdata);
        plan_read(ra, dr, rv);
      end else
        push(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, m_rdata);
    end else if (rd) begin
      push(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, m_rdata);
      plan_read(ra, dr, rv);
    end else begin
      push(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, m_rdata);
    end
    i = 0;
    while (q.size() > 0 && i < 200) begin
      @(posedge clk);
      i++;
    end
    chk("drain_bound", q.size(), 0);
    #1;
  endtask

  localparam logic [127:0] RV1 = 128'hDEADBEEF_01234567_89ABCDEF_FEEDFACE;
  localparam logic [127:0] WD2 = 128'h11111111_11111111_11111111_11111111;
  localparam logic [127:0] RV2 = 128'h30303030_A5A5A5A5_5A5A5A5A_C3C3C3C3;
  localparam logic [127:0] RV5 = 128'h55555555_66666666_77777777_88888888;

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_strobes", {mem_read, mem_write, resp_valid, resp_err}, 4'b0000);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_rdata", resp_rdata, '0);
    chk("rst_addr", mem_addr, '0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Refill only, memory ready on the 4th strobe cycle.
    do_req(1'b0, '0, '0, 1'b1, 28'h0000010, 0, 4, RV1);
    chk("t1_read_cycles", rd_hi, 4);
    chk("t1_write_cycles", wr_hi, 0);
    chk("t1_resp_count", resp_cnt, 1);
    chk("t1_latency", resp_cyc - acc_cyc, 6);
    chk("t1_rdata", resp_rdata, RV1);

    // Writeback + refill, both ready immediately: minimum latency 5.
    do_req(1'b1, 28'h0000020, WD2, 1'b1, 28'h0000030, 1, 1, RV2);
    chk("t2_latency", resp_cyc - acc_cyc, 5);
    chk("t2_mem_addr_written", last_waddr, 28'h0000020);
    chk("t2_mem_data_written", last_wdata, WD2);
    chk("t2_strobe_cycles", {wr_hi[7:0], rd_hi[7:0]}, 16'h0101);
    chk("t2_rdata", resp_rdata, RV2);

    // No-op: one cycle, no traffic, refill line unchanged.
    do_req(1'b0, 28'h0000070, RV1, 1'b0, 28'h0000071, 1, 1, RV1);
    chk("t3_latency", resp_cyc - acc_cyc, 1);
    chk("t3_strobes", rd_hi + wr_hi, 0);
    chk("t3_rdata_held", resp_rdata, RV2);

    // Refill timeout: 8 strobe cycles then error completion.
    do_req(1'b0, '0, '0, 1'b1, 28'h0000040, 0, 0, RV1);
    chk("t4_read_cycles", rd_hi, 8);
    chk("t4_latency", resp_cyc - acc_cyc, 10);
    chk("t4_rdata_zero", resp_rdata, '0);
    chk("t4_stall_total", stall_cnt, 22);
    chk("t4_stall_saturated", s_stall, 4'hF);

    // Next request after a timeout proceeds normally: minimum latency 3.
    do_req(1'b0, '0, '0, 1'b1, 28'h0000050, 0, 1, RV5);
    chk("t5_latency", resp_cyc - acc_cyc, 3);
    chk("t5_rdata", resp_rdata, RV5);

    // Writeback timeout with a refill pending: refill is skipped.
    do_req(1'b1, 28'h0000060, RV5, 1'b1, 28'h0000061, 0, 1, RV1);
    chk("t6_write_cycles", wr_hi, 8);
    chk("t6_read_cycles", rd_hi, 0);
    chk("t6_rdata_zero", resp_rdata, '0);

    // Stray mem_ready while idle is ignored.
    @(posedge clk); #2 stray = 1'b1;
    @(posedge clk); #2 stray = 1'b0;
    chk("t7_ready_after_stray", req_ready, 1'b1);
    chk("t7_strobes_after_stray", {mem_read, mem_write, resp_valid}, 3'b000);
    repeat (2) @(posedge clk);

    // Reset in the middle of a refill.
    @(posedge clk); #2;
    dly_rd = 0; resp_cnt = 0;
    req_valid = 1'b1; req_wb = 1'b0; req_rd = 1'b1; req_rd_addr = 28'h0000080;
    @(posedge clk); #2;
    req_valid = 1'b0;
    push(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, m_rdata);
    for (int k = 0; k < 3; k++) push(1'b1, 1'b0, 1'b0, 1'b0, 28'h0000080, '0, m_rdata);
    repeat (2) @(posedge clk);
    #1;
    chk("t8_read_before_reset", mem_read, 1'b1);
    rst_n = 1'b0;
    q.delete();
    m_rdata = '0;
    m_stall = 0;
    #1;
    chk("t8_read_dropped", mem_read, 1'b0);
    chk("t8_ready_after_reset", req_ready, 1'b1);
    chk("t8_stall_cleared", stall_cnt, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t8_no_response", resp_cnt, 0);

    // Normal operation after reset.
    do_req(1'b0, '0, '0, 1'b1, 28'h0000090, 0, 1, RV2);
    chk("t9_latency", resp_cyc - acc_cyc, 3);
    chk("t9_rdata", resp_rdata, RV2);
    chk("t9_stall", stall_cnt, 3);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
